line_scan_sequencer: RTL and testbench

- Upstream driver for the 3-to-8 line decoder (`Line_Decoder`).
- Steps the decoder's select inputs through the lines enabled in a mask, holding each selected line for a programmable dwell time.
- Supports one-shot and continuous scanning.
- Outputs Enable, A, B and C connect straight to the decoder inputs of the same names, so exactly one decoder output F[i] is active while scanning.

---
 rtl/line_scan_sequencer.sv | 154 +++++++++++++++
 tb/tb_line_scan_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : line_scan_sequencer
// Description : Drives the select inputs of a 3-to-8 line decoder, stepping
//               through the lines enabled in a mask and holding each one for
//               dwell+1 cycles. Supports one-shot and continuous scanning.
// Ports       : clk      - system clock, rising edge
//               reset    - synchronous active-high reset
//               start    - begin a scan (IDLE only)
//               stop     - abort a scan (SCAN only)
//               oneshot  - 1 = single frame, 0 = continuous (captured at start)
//               mask     - lines to visit (captured at start)
//               dwell    - per-line hold is dwell+1 cycles (captured at start)
//               Enable   - decoder enable, high only while scanning
//               A, B, C  - decoder select, A is MSB
//               busy     - high while scanning
//               done     - one-cycle pulse at the end of each frame
// Revision    : 1.0 - initial release
// ============================================================================
module line_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               oneshot,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               Enable,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               busy,
    output logic               done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t             r_state;
    logic [2:0]         r_idx;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell;
    logic [7:0]         r_mask;
    logic               r_oneshot;
    logic               r_enable;
    logic               r_busy;
    logic               r_done;

    logic               w_has_next;
    logic [2:0]         w_next_idx;
    logic [2:0]         w_start_idx;
    logic [2:0]         w_wrap_idx;
    logic               w_expired;

    // Index of the lowest set bit; callers guarantee the mask is nonzero.
    function automatic logic [2:0] f_lowest(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Next enabled line strictly above the current one. Scanning downward
    // lets the lowest qualifying bit win.
    always_comb begin
        w_has_next = 1'b0;
        w_next_idx = r_idx;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i] && (3'(i) > r_idx)) begin
                w_has_next = 1'b1;
                w_next_idx = 3'(i);
            end
        end
    end

    assign w_start_idx = f_lowest(mask);
    assign w_wrap_idx  = f_lowest(r_mask);
    assign w_expired   = (r_cnt == r_dwell);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_cnt     <= '0;
            r_dwell   <= '0;
            r_mask    <= 8'd0;
            r_oneshot <= 1'b0;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && (mask != 8'd0)) begin
                        r_state   <= S_SCAN;
                        r_mask    <= mask;
                        r_dwell   <= dwell;
                        r_oneshot <= oneshot;
                        r_idx     <= w_start_idx;
                        r_cnt     <= '0;
                        r_enable  <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_SCAN: begin
                    // stop outranks dwell expiry and frame completion.
                    if (stop) begin
                        r_state  <= S_IDLE;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (w_expired) begin
                        r_cnt <= '0;
                        if (w_has_next) begin
                            r_idx <= w_next_idx;
                        end else if (r_oneshot) begin
                            // Index is left on the final line.
                            r_state  <= S_IDLE;
                            r_enable <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_idx  <= w_wrap_idx;
                            r_done <= 1'b1;
                        end
                    end else begin
                        // Cannot wrap: it is cleared once it reaches r_dwell.
                        r_cnt <= r_cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign Enable = r_enable;
    assign A      = r_idx[2];
    assign B      = r_idx[1];
    assign C      = r_idx[0];
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_line_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_scan_sequencer
// Description : Directed self-checking bench for line_scan_sequencer.
//               Observed vector is {Enable, A, B, C, busy, done}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_scan_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       oneshot;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic       Enable;
    logic       A;
    logic       B;
    logic       C;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;

    line_scan_sequencer #(.DWELL_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .oneshot (oneshot),
        .mask    (mask),
        .dwell   (dwell),
        .Enable  (Enable),
        .A       (A),
        .B       (B),
        .C       (C),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [5:0] obs = {Enable, A, B, C, busy, done};

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mask = 8'hFF; dwell = 8'd0; oneshot = 1'b0;
        tick();
        tick();
        tests_run++;
        if (obs !== 6'b0_000_00) begin
            tests_failed++;
            $display("FAIL reset: got %b want %b", obs, 6'b0_000_00);
        end
        reset = 1'b0; start = 1'b0;
        tick();
        tests_run++;
        if (obs !== 6'b0_000_00) begin
            tests_failed++;
            $display("FAIL reset_release: got %b want %b", obs, 6'b0_000_00);
        end
    endtask

    task automatic test_oneshot();
        logic [5:0] exp [0:7];
        exp = '{6'b1_000_10, 6'b1_000_10, 6'b1_010_10, 6'b1_010_10,
                6'b1_101_10, 6'b1_101_10, 6'b0_101_01, 6'b0_101_00};
        mask = 8'b0010_0101; dwell = 8'd1; oneshot = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            tests_run++;
            if (obs !== exp[k]) begin
                tests_failed++;
                $display("FAIL oneshot edge %0d: got %b want %b", k, obs, exp[k]);
            end
        end
    endtask

    task automatic test_continuous();
        logic [5:0] e;
        mask = 8'h81; dwell = 8'd0; oneshot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            if (k % 2 == 1)  e = 6'b1_111_10;
            else if (k == 0) e = 6'b1_000_10;
            else             e = 6'b1_000_11;
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL continuous edge %0d: got %b want %b", k, obs, e);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++;
        if (obs !== 6'b0_111_00) begin
            tests_failed++;
            $display("FAIL continuous_stop: got %b want %b", obs, 6'b0_111_00);
        end
        // Single line, continuous: held forever, done every dwell+1 cycles.
        mask = 8'h10; dwell = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            e = {5'b1_100_1, (k > 0 && k % 3 == 0)};
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL single_line edge %0d: got %b want %b", k, obs, e);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_stop();
        mask = 8'hFF; dwell = 8'd3; oneshot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        tests_run++;
        if (obs !== 6'b1_001_10) begin
            tests_failed++;
            $display("FAIL stop_pre: got %b want %b", obs, 6'b1_001_10);
        end
        // Dwell on line 1 expires at this edge; stop must win.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++;
        if (obs !== 6'b0_001_00) begin
            tests_failed++;
            $display("FAIL stop_edge: got %b want %b", obs, 6'b0_001_00);
        end
        tick();
        tests_run++;
        if (obs !== 6'b0_001_00) begin
            tests_failed++;
            $display("FAIL stop_after: got %b want %b", obs, 6'b0_001_00);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++;
        if (obs !== 6'b0_001_00) begin
            tests_failed++;
            $display("FAIL stop_in_idle: got %b want %b", obs, 6'b0_001_00);
        end
    endtask

    task automatic test_ignored();
        logic [5:0] exp [0:5];
        exp = '{6'b1_000_10, 6'b1_001_10, 6'b1_010_10, 6'b1_011_10,
                6'b0_011_01, 6'b0_011_00};
        mask = 8'h00; dwell = 8'd0; oneshot = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (obs !== 6'b0_001_00) begin
            tests_failed++;
            $display("FAIL zero_mask_start: got %b want %b", obs, 6'b0_001_00);
        end
        mask = 8'h0F; start = 1'b1;
        tick();
        start = 1'b0;
        mask = 8'hF0; dwell = 8'd5; oneshot = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            // Restart attempt during SCAN, sampled at edge 2.
            start = (k == 1);
            tests_run++;
            if (obs !== exp[k]) begin
                tests_failed++;
                $display("FAIL ignored edge %0d: got %b want %b", k, obs, exp[k]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        mask = 8'hFF; dwell = 8'd0; oneshot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tests_run++;
        if (obs !== 6'b1_010_10) begin
            tests_failed++;
            $display("FAIL mid_pre: got %b want %b", obs, 6'b1_010_10);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (obs !== 6'b0_000_00) begin
            tests_failed++;
            $display("FAIL mid_reset: got %b want %b", obs, 6'b0_000_00);
        end
        mask = 8'b0100_1000; start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (obs !== 6'b1_011_10) begin
            tests_failed++;
            $display("FAIL restart_first: got %b want %b", obs, 6'b1_011_10);
        end
        tick();
        tests_run++;
        if (obs !== 6'b1_110_10) begin
            tests_failed++;
            $display("FAIL restart_second: got %b want %b", obs, 6'b1_110_10);
        end
        tick();
        tests_run++;
        if (obs !== 6'b1_011_11) begin
            tests_failed++;
            $display("FAIL restart_wrap: got %b want %b", obs, 6'b1_011_11);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
        mask = 8'h00; dwell = 8'd0;
        test_reset();
        test_oneshot();
        test_continuous();
        test_stop();
        test_ignored();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
